// File: rtl/scr1_tapc_pkg.sv
// rtl/scr1_tapc_pkg.sv - shared TAP state encoding, DR indices and default opcodes
package scr1_tapc_pkg;

    localparam int unsigned SCR1_IR_WIDTH_DEF = 5;
    localparam logic [4:0]  SCR1_IR_IDCODE_DEF = 5'h01;
    localparam logic [4:0]  SCR1_IR_DTMCS_DEF  = 5'h10;
    localparam logic [4:0]  SCR1_IR_DMI_DEF    = 5'h11;
    localparam logic [4:0]  SCR1_IR_BYPASS_DEF = 5'h1F;

    localparam int unsigned SCR1_TAP_DR_NUM    = 4;
    localparam logic [1:0]  SCR1_TAP_DR_BYPASS = 2'd0;
    localparam logic [1:0]  SCR1_TAP_DR_IDCODE = 2'd1;
    localparam logic [1:0]  SCR1_TAP_DR_DTMCS  = 2'd2;
    localparam logic [1:0]  SCR1_TAP_DR_DMI    = 2'd3;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EX1_DR,
        TAP_PAUSE_DR,
        TAP_EX2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EX1_IR,
        TAP_PAUSE_IR,
        TAP_EX2_IR,
        TAP_UPD_IR
    } type_scr1_tap_state_e;

endpackage

// File: rtl/scr1_tapc_fsm.sv
// rtl/scr1_tapc_fsm.sv - 16-state TAP state register with Moore strobe decode
module scr1_tapc_fsm
    import scr1_tapc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tms,
    output type_scr1_tap_state_e state,
    output logic                 dr_capture,
    output logic                 dr_shift,
    output logic                 dr_update,
    output logic                 reset_n,
    output logic                 tdo_en
);

    type_scr1_tap_state_e state_q;
    type_scr1_tap_state_e state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_d = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_d = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    assign state      = state_q;
    assign dr_capture = (state_q == TAP_CAP_DR);
    assign dr_shift   = (state_q == TAP_SHIFT_DR);
    assign dr_update  = (state_q == TAP_UPD_DR);
    assign reset_n    = (state_q != TAP_TLR);
    assign tdo_en     = (state_q == TAP_SHIFT_DR) || (state_q == TAP_SHIFT_IR);

endmodule

// File: rtl/scr1_tapc_ctrl.sv
// rtl/scr1_tapc_ctrl.sv - TAP controller top: IR, instruction decode and TDO mux
module scr1_tapc_ctrl
    import scr1_tapc_pkg::*;
#(
    parameter int unsigned                SCR1_IR_WIDTH  = SCR1_IR_WIDTH_DEF,
    parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_IDCODE = SCR1_IR_WIDTH'(SCR1_IR_IDCODE_DEF),
    parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_DTMCS  = SCR1_IR_WIDTH'(SCR1_IR_DTMCS_DEF),
    parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_DMI    = SCR1_IR_WIDTH'(SCR1_IR_DMI_DEF),
    parameter logic [SCR1_IR_WIDTH-1:0]   SCR1_IR_BYPASS = SCR1_IR_WIDTH'(SCR1_IR_BYPASS_DEF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tms,
    input  logic                     tdi,
    input  logic [3:0]               dr_dout_serial,
    output logic [3:0]               fsm_dr_select,
    output logic                     fsm_dr_capture,
    output logic                     fsm_dr_shift,
    output logic                     fsm_dr_update,
    output logic                     fsm_reset_n,
    output logic [SCR1_IR_WIDTH-1:0] ir_value,
    output logic                     tdo,
    output logic                     tdo_en
);

    localparam logic [SCR1_IR_WIDTH-1:0] IR_CAPTURE = SCR1_IR_WIDTH'(2'b01);

    type_scr1_tap_state_e     fsm_state;
    logic [SCR1_IR_WIDTH-1:0] ir_shift_q;
    logic [SCR1_IR_WIDTH-1:0] ir_shift_d;
    logic [SCR1_IR_WIDTH-1:0] ir_value_q;
    logic [SCR1_IR_WIDTH-1:0] ir_value_d;
    logic [1:0]               dr_idx;

    scr1_tapc_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .tms        (tms),
        .state      (fsm_state),
        .dr_capture (fsm_dr_capture),
        .dr_shift   (fsm_dr_shift),
        .dr_update  (fsm_dr_update),
        .reset_n    (fsm_reset_n),
        .tdo_en     (tdo_en)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_shift_q <= IR_CAPTURE;
            ir_value_q <= SCR1_IR_IDCODE;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_value_q <= ir_value_d;
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_value_d = ir_value_q;
        case (fsm_state)
            TAP_CAP_IR:   ir_shift_d = IR_CAPTURE;
            TAP_SHIFT_IR: ir_shift_d = {tdi, ir_shift_q[SCR1_IR_WIDTH-1:1]};
            TAP_UPD_IR:   ir_value_d = ir_shift_q;
            TAP_TLR:      ir_value_d = SCR1_IR_IDCODE;
            default:      ;
        endcase
    end

    // Anything not explicitly recognised, including the BYPASS opcode itself, selects BYPASS
    always_comb begin
        dr_idx = SCR1_TAP_DR_BYPASS;
        if (ir_value_q == SCR1_IR_IDCODE) begin
            dr_idx = SCR1_TAP_DR_IDCODE;
        end else if (ir_value_q == SCR1_IR_DTMCS) begin
            dr_idx = SCR1_TAP_DR_DTMCS;
        end else if (ir_value_q == SCR1_IR_DMI) begin
            dr_idx = SCR1_TAP_DR_DMI;
        end
    end

    always_comb begin
        tdo = 1'b0;
        case (fsm_state)
            TAP_SHIFT_IR: tdo = ir_shift_q[0];
            TAP_SHIFT_DR: tdo = dr_dout_serial[dr_idx];
            default:      tdo = 1'b0;
        endcase
    end

    assign fsm_dr_select = 4'b0001 << dr_idx;
    assign ir_value      = ir_value_q;

endmodule

// File: tb/tb_scr1_tapc_ctrl.sv
// tb/tb_scr1_tapc_ctrl.sv - directed self-checking bench for scr1_tapc_ctrl
module tb_scr1_tapc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tms;
    logic       tdi;
    logic [3:0] dr_dout_serial;
    logic [3:0] fsm_dr_select;
    logic       fsm_dr_capture;
    logic       fsm_dr_shift;
    logic       fsm_dr_update;
    logic       fsm_reset_n;
    logic [4:0] ir_value;
    logic       tdo;
    logic       tdo_en;

    int total = 0;
    int bad   = 0;

    scr1_tapc_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tms            (tms),
        .tdi            (tdi),
        .dr_dout_serial (dr_dout_serial),
        .fsm_dr_select  (fsm_dr_select),
        .fsm_dr_capture (fsm_dr_capture),
        .fsm_dr_shift   (fsm_dr_shift),
        .fsm_dr_update  (fsm_dr_update),
        .fsm_reset_n    (fsm_reset_n),
        .ir_value       (ir_value),
        .tdo            (tdo),
        .tdo_en         (tdo_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rti();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    // From RTI: shift a full opcode LSB-first and return to RTI through UPD_IR
    task automatic load_ir(input logic [4:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(i == 4, op[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        total++; if (ir_value !== 5'h01) begin bad++; $display("FAIL rst_ir_value got=%h exp=01", ir_value); end
        total++; if (fsm_dr_select !== 4'b0010) begin bad++; $display("FAIL rst_select got=%b exp=0010", fsm_dr_select); end
        total++; if (fsm_reset_n !== 1'b0) begin bad++; $display("FAIL rst_reset_n got=%b exp=0", fsm_reset_n); end
        total++; if ({fsm_dr_capture, fsm_dr_shift, fsm_dr_update, tdo, tdo_en} !== 5'b0) begin
            bad++; $display("FAIL rst_strobes got=%b exp=00000", {fsm_dr_capture, fsm_dr_shift, fsm_dr_update, tdo, tdo_en}); end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        total++; if (fsm_dr_shift !== 1'b1) begin bad++; $display("FAIL reach_shift_dr got=%b exp=1", fsm_dr_shift); end
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        total++; if ({fsm_reset_n, fsm_dr_shift, tdo_en} !== 3'b000) begin
            bad++; $display("FAIL midshift_rst got=%b exp=000", {fsm_reset_n, fsm_dr_shift, tdo_en}); end
        total++; if (ir_value !== 5'h01 || fsm_dr_select !== 4'b0010) begin
            bad++; $display("FAIL midshift_rst_ir got=%h/%b exp=01/0010", ir_value, fsm_dr_select); end
    endtask

    task automatic test_tlr_ones();
        goto_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b0) begin bad++; $display("FAIL tlr_from_rti got=%b exp=0", fsm_reset_n); end

        goto_rti();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        total++; if (tdo_en !== 1'b1) begin bad++; $display("FAIL reach_shift_ir got=%b exp=1", tdo_en); end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b1) begin bad++; $display("FAIL tlr_shift_ir_4th got=%b exp=1", fsm_reset_n); end
        step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b0) begin bad++; $display("FAIL tlr_shift_ir_5th got=%b exp=0", fsm_reset_n); end

        goto_rti();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b1) begin bad++; $display("FAIL tlr_pause_dr_4th got=%b exp=1", fsm_reset_n); end
        step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b0) begin bad++; $display("FAIL tlr_pause_dr_5th got=%b exp=0", fsm_reset_n); end

        goto_rti();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        total++; if (fsm_reset_n !== 1'b0) begin bad++; $display("FAIL tlr_upd_ir got=%b exp=0", fsm_reset_n); end
    endtask

    task automatic test_ir_load();
        logic [4:0] bits;
        logic [4:0] exp_tdo;
        bits    = 5'b10001;
        exp_tdo = 5'b00001;
        goto_rti();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            total++; if (tdo !== exp_tdo[i] || tdo_en !== 1'b1) begin
                bad++; $display("FAIL ir_tdo[%0d] got=%b/%b exp=%b/1", i, tdo, tdo_en, exp_tdo[i]); end
            step(i == 4, bits[i]);
        end
        step(1'b1, 1'b0);
        total++; if (ir_value !== 5'h01) begin bad++; $display("FAIL ir_in_upd got=%h exp=01", ir_value); end
        step(1'b0, 1'b0);
        total++; if (ir_value !== 5'h11) begin bad++; $display("FAIL ir_after_upd got=%h exp=11", ir_value); end
        total++; if (fsm_dr_select !== 4'b1000) begin bad++; $display("FAIL ir_dmi_select got=%b exp=1000", fsm_dr_select); end
    endtask

    task automatic test_decode();
        goto_rti();
        load_ir(5'h10);
        total++; if (fsm_dr_select !== 4'b0100) begin bad++; $display("FAIL dtmcs_select got=%b exp=0100", fsm_dr_select); end
        load_ir(5'h07);
        total++; if (ir_value !== 5'h07 || fsm_dr_select !== 4'b0001) begin
            bad++; $display("FAIL undef_select got=%h/%b exp=07/0001", ir_value, fsm_dr_select); end
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        dr_dout_serial = 4'b0001;
        #1;
        total++; if (tdo !== 1'b1) begin bad++; $display("FAIL bypass_tdo_hi got=%b exp=1", tdo); end
        dr_dout_serial = 4'b1110;
        #1;
        total++; if (tdo !== 1'b0) begin bad++; $display("FAIL bypass_tdo_lo got=%b exp=0", tdo); end
        load_ir(5'h1F);
        total++; if (fsm_dr_select !== 4'b0001) begin bad++; $display("FAIL bypass_select got=%b exp=0001", fsm_dr_select); end
        dr_dout_serial = 4'b0000;
    endtask

    task automatic test_dr_dmi();
        logic [8:0] tms_seq;
        logic [8:0] exp_shift;
        logic       b;
        int         n_cap;
        int         n_shift;
        int         n_upd;
        tms_seq   = 9'b011000001;
        exp_shift = 9'b000111100;
        n_cap = 0; n_shift = 0; n_upd = 0;
        goto_rti();
        load_ir(5'h11);
        for (int k = 0; k < 9; k++) begin
            b = k[0];
            dr_dout_serial = {b, ~b, ~b, ~b};
            step(tms_seq[k], 1'b0);
            n_cap   += int'(fsm_dr_capture);
            n_shift += int'(fsm_dr_shift);
            n_upd   += int'(fsm_dr_update);
            total++; if (tdo !== (exp_shift[k] & b) || tdo_en !== exp_shift[k]) begin
                bad++; $display("FAIL dmi_tdo[%0d] got=%b/%b exp=%b/%b", k, tdo, tdo_en, exp_shift[k] & b, exp_shift[k]); end
            total++; if (fsm_dr_select !== 4'b1000) begin bad++; $display("FAIL dmi_select[%0d] got=%b exp=1000", k, fsm_dr_select); end
        end
        total++; if (n_cap !== 1 || n_shift !== 4 || n_upd !== 1) begin
            bad++; $display("FAIL dmi_strobe_counts got=%0d/%0d/%0d exp=1/4/1", n_cap, n_shift, n_upd); end
        dr_dout_serial = 4'b0000;
    endtask

    task automatic test_pause();
        logic [4:0] d;
        d = 5'h11;
        goto_rti();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, d[0]);
        step(1'b1, d[1]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        total++; if (tdo_en !== 1'b0 || tdo !== 1'b0) begin bad++; $display("FAIL pause_tdo got=%b/%b exp=0/0", tdo_en, tdo); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++; if (tdo_en !== 1'b1 || tdo !== 1'b0) begin bad++; $display("FAIL resume_tdo got=%b/%b exp=1/0", tdo_en, tdo); end
        step(1'b0, d[2]);
        step(1'b0, d[3]);
        step(1'b1, d[4]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++; if (ir_value !== 5'h11 || fsm_dr_select !== 4'b1000) begin
            bad++; $display("FAIL pause_ir got=%h/%b exp=11/1000", ir_value, fsm_dr_select); end
    endtask

    initial begin
        rst_n          = 1'b0;
        tms            = 1'b1;
        tdi            = 1'b0;
        dr_dout_serial = 4'b0000;
        test_reset();
        test_tlr_ones();
        test_ir_load();
        test_decode();
        test_dr_dmi();
        test_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
